// File: rtl/isa_switch_ctrl_if.sv
// Bus between the pipeline/hazard unit and the ISA switch controller.
// Signal names match the pipeline's existing control nets.
interface isa_switch_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             SwitchReqE;
    logic             SwitchArmE;
    logic [31:0]      SwitchTargetE;
    logic             HzStallF;
    logic             HzStallD;
    logic             HzFlushD;
    logic             HzFlushE;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic             armD;
    logic             PCRedirect;
    logic [31:0]      PCTarget;
    logic             Busy;
    logic [CNT_W-1:0] SwitchCnt;

    modport master (
        output SwitchReqE, SwitchArmE, SwitchTargetE,
        output HzStallF, HzStallD, HzFlushD, HzFlushE,
        input  StallF, StallD, FlushD, FlushE,
        input  armD, PCRedirect, PCTarget, Busy, SwitchCnt
    );

    modport slave (
        input  SwitchReqE, SwitchArmE, SwitchTargetE,
        input  HzStallF, HzStallD, HzFlushD, HzFlushE,
        output StallF, StallD, FlushD, FlushE,
        output armD, PCRedirect, PCTarget, Busy, SwitchCnt
    );
endinterface

// File: rtl/isa_switch_ctrl.sv
// ISA mode switch sequencer: flushes and drains the back end, redirects fetch
// to the aligned switch target and flips the decode ISA mode.
module isa_switch_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter bit          RESET_ARM    = 1'b0,
    parameter int unsigned CNT_W        = 16
) (
    input logic               clk,
    input logic               rst,
    isa_switch_ctrl_if.slave  bus
);
    localparam int unsigned DRAIN_W = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        DRAIN  = 2'd2,
        SWITCH = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               arm_q, arm_d;
    logic               tgt_arm_q, tgt_arm_d;
    logic [31:1]        tgt_q, tgt_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic stall_f_c, stall_d_c, flush_d_c, flush_e_c, redirect_c;
    logic unused_tgt0_c;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            arm_q     <= RESET_ARM;
            tgt_arm_q <= RESET_ARM;
            tgt_q     <= '0;
            drain_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            arm_q     <= arm_d;
            tgt_arm_q <= tgt_arm_d;
            tgt_q     <= tgt_d;
            drain_q   <= drain_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state and pipeline-control decode
    always_comb begin
        state_d    = state_q;
        arm_d      = arm_q;
        tgt_arm_d  = tgt_arm_q;
        tgt_d      = tgt_q;
        drain_d    = drain_q;
        cnt_d      = cnt_q;
        stall_f_c  = 1'b0;
        stall_d_c  = 1'b0;
        flush_d_c  = 1'b0;
        flush_e_c  = 1'b0;
        redirect_c = 1'b0;

        unique case (state_q)
            RUN: begin
                stall_f_c = bus.HzStallF;
                stall_d_c = bus.HzStallD;
                flush_d_c = bus.HzFlushD;
                flush_e_c = bus.HzFlushE;
                // Requests for the mode already active are no-ops
                if (bus.SwitchReqE && (bus.SwitchArmE != arm_q)) begin
                    state_d   = FLUSH;
                    tgt_arm_d = bus.SwitchArmE;
                    tgt_d     = bus.SwitchTargetE[31:1];
                end
            end
            FLUSH: begin
                stall_f_c = 1'b1;
                flush_d_c = 1'b1;
                flush_e_c = 1'b1;
                drain_d   = DRAIN_W'(DRAIN_CYCLES);
                state_d   = DRAIN;
            end
            DRAIN: begin
                stall_f_c = 1'b1;
                flush_d_c = 1'b1;
                flush_e_c = 1'b1;
                drain_d   = drain_q - DRAIN_W'(1);
                if (drain_q <= DRAIN_W'(1)) begin
                    state_d = SWITCH;
                end
            end
            SWITCH: begin
                redirect_c = 1'b1;
                flush_d_c  = 1'b1;
                flush_e_c  = 1'b1;
                arm_d      = tgt_arm_q;
                cnt_d      = cnt_q + CNT_W'(1);
                state_d    = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // ARM targets are word aligned, RISC-V targets halfword aligned
    assign bus.PCTarget = {tgt_q[31:2], (tgt_arm_q ? 1'b0 : tgt_q[1]), 1'b0};

    assign bus.StallF     = stall_f_c;
    assign bus.StallD     = stall_d_c;
    assign bus.FlushD     = flush_d_c;
    assign bus.FlushE     = flush_e_c;
    assign bus.PCRedirect = redirect_c;
    assign bus.armD       = arm_q;
    assign bus.Busy       = (state_q != RUN);
    assign bus.SwitchCnt  = cnt_q;

    assign unused_tgt0_c = bus.SwitchTargetE[0];
endmodule

// File: tb/tb_isa_switch_ctrl.sv
// Bench for isa_switch_ctrl: scoreboarded redirects plus per-cycle sequence checks.
module tb_isa_switch_ctrl;
    localparam int unsigned DRAIN = 3;

    typedef struct {
        logic [31:0] tgt;
        logic        arm;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    exp_t sb_q[$];

    isa_switch_ctrl_if #(.CNT_W(16)) bus ();
    isa_switch_ctrl_if #(.CNT_W(4))  bus_w ();

    isa_switch_ctrl #(.DRAIN_CYCLES(DRAIN), .RESET_ARM(1'b0), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    isa_switch_ctrl #(.DRAIN_CYCLES(1), .RESET_ARM(1'b1), .CNT_W(4)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Redirect monitor: each redirect must match the oldest outstanding request
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (bus.PCRedirect === 1'b1) begin
            n_chk++;
            if (sb_q.size() == 0) begin
                $display("FAIL redirect_unexpected: PCTarget=%h with no request pending", bus.PCTarget);
            end else begin
                e = sb_q.pop_front();
                if (bus.PCTarget !== e.tgt)
                    $display("FAIL redirect_target: got %h expected %h", bus.PCTarget, e.tgt);
                else
                    n_pass++;
            end
        end
    end

    task automatic drive_idle();
        bus.SwitchReqE = 1'b0; bus.SwitchArmE = 1'b0; bus.SwitchTargetE = '0;
        bus.HzStallF = 1'b0; bus.HzStallD = 1'b0; bus.HzFlushD = 1'b0; bus.HzFlushE = 1'b0;
        bus_w.SwitchReqE = 1'b0; bus_w.SwitchArmE = 1'b0; bus_w.SwitchTargetE = '0;
        bus_w.HzStallF = 1'b0; bus_w.HzStallD = 1'b0; bus_w.HzFlushD = 1'b0; bus_w.HzFlushE = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        #12;
        n_chk++;
        if ({bus.Busy, bus.armD, bus.PCRedirect, bus.StallF, bus.StallD, bus.FlushD, bus.FlushE} !== 7'b0)
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {bus.Busy, bus.armD, bus.PCRedirect, bus.StallF, bus.StallD, bus.FlushD, bus.FlushE});
        else n_pass++;
        n_chk++;
        if (bus.SwitchCnt !== 16'd0) $display("FAIL reset_cnt: got %0d expected 0", bus.SwitchCnt);
        else n_pass++;
        n_chk++;
        if (bus_w.armD !== 1'b1) $display("FAIL reset_arm_param: got %b expected 1", bus_w.armD);
        else n_pass++;
        bus.HzStallF = 1'b1;
        #1;
        n_chk++;
        if (bus.StallF !== 1'b1) $display("FAIL reset_passthrough: StallF=%b expected 1", bus.StallF);
        else n_pass++;
        bus.HzStallF = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic do_switch(input logic arm, input logic [31:0] tgt, input logic [31:0] exp_tgt,
                             input logic hzd, input logic [15:0] exp_cnt);
        logic old_arm;
        old_arm = ~arm;
        @(negedge clk);
        bus.SwitchReqE = 1'b1; bus.SwitchArmE = arm; bus.SwitchTargetE = tgt; bus.HzStallD = hzd;
        sb_q.push_back('{exp_tgt, arm});
        #1;
        n_chk++;
        if ({bus.Busy, bus.StallD} !== {1'b0, hzd})
            $display("FAIL req_cycle: Busy,StallD=%b expected %b", {bus.Busy, bus.StallD}, {1'b0, hzd});
        else n_pass++;
        @(negedge clk);
        bus.SwitchReqE = 1'b0; bus.HzStallD = 1'b0;
        #1;
        n_chk++;
        if ({bus.Busy, bus.StallF, bus.StallD, bus.FlushD, bus.FlushE, bus.PCRedirect} !== 6'b110110)
            $display("FAIL flush_cycle: got %b expected 110110",
                     {bus.Busy, bus.StallF, bus.StallD, bus.FlushD, bus.FlushE, bus.PCRedirect});
        else n_pass++;
        for (int i = 0; i < int'(DRAIN); i++) begin
            @(negedge clk);
            bus.HzStallD = 1'b1; bus.SwitchReqE = 1'b1; bus.SwitchArmE = old_arm;
            #1;
            n_chk++;
            if ({bus.Busy, bus.StallF, bus.StallD, bus.FlushD, bus.FlushE, bus.PCRedirect, bus.armD}
                    !== {6'b110110, old_arm})
                $display("FAIL drain_cycle%0d: got %b expected %b", i,
                         {bus.Busy, bus.StallF, bus.StallD, bus.FlushD, bus.FlushE, bus.PCRedirect, bus.armD},
                         {6'b110110, old_arm});
            else n_pass++;
        end
        @(negedge clk);
        bus.HzStallD = 1'b0; bus.SwitchReqE = 1'b0;
        #1;
        n_chk++;
        if ({bus.Busy, bus.StallF, bus.StallD, bus.FlushD, bus.FlushE, bus.PCRedirect, bus.armD}
                !== {6'b100111, old_arm})
            $display("FAIL switch_cycle: got %b expected %b",
                     {bus.Busy, bus.StallF, bus.StallD, bus.FlushD, bus.FlushE, bus.PCRedirect, bus.armD},
                     {6'b100111, old_arm});
        else n_pass++;
        @(negedge clk);
        #1;
        n_chk++;
        if ({bus.Busy, bus.armD, bus.SwitchCnt} !== {1'b0, arm, exp_cnt})
            $display("FAIL after_switch: Busy=%b armD=%b cnt=%0d expected 0 %b %0d",
                     bus.Busy, bus.armD, bus.SwitchCnt, arm, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_same_mode();
        @(negedge clk);
        bus.SwitchReqE = 1'b1; bus.SwitchArmE = bus.armD; bus.SwitchTargetE = 32'h0000_3000;
        repeat (3) @(negedge clk);
        bus.SwitchReqE = 1'b0;
        #1;
        n_chk++;
        if ({bus.Busy, bus.SwitchCnt} !== {1'b0, 16'd2})
            $display("FAIL same_mode: Busy=%b cnt=%0d expected 0 2", bus.Busy, bus.SwitchCnt);
        else n_pass++;
    endtask

    task automatic test_passthrough();
        for (int p = 0; p < 16; p++) begin
            logic [3:0] pat;
            pat = 4'(p);
            @(negedge clk);
            {bus.HzStallF, bus.HzStallD, bus.HzFlushD, bus.HzFlushE} = pat;
            #1;
            n_chk++;
            if ({bus.StallF, bus.StallD, bus.FlushD, bus.FlushE, bus.PCRedirect} !== {pat, 1'b0})
                $display("FAIL passthrough_%0d: got %b expected %b", p,
                         {bus.StallF, bus.StallD, bus.FlushD, bus.FlushE, bus.PCRedirect}, {pat, 1'b0});
            else n_pass++;
        end
        @(negedge clk);
        {bus.HzStallF, bus.HzStallD, bus.HzFlushD, bus.HzFlushE} = 4'b0;
    endtask

    task automatic test_reset_mid_drain();
        int busy_seen;
        exp_t dropped;
        @(negedge clk);
        bus.SwitchReqE = 1'b1; bus.SwitchArmE = 1'b1; bus.SwitchTargetE = 32'h0000_4000;
        sb_q.push_back('{32'h0000_4000, 1'b1});
        @(negedge clk);
        bus.SwitchReqE = 1'b0;
        @(negedge clk);
        #3 rst = 1'b0;
        #1;
        n_chk++;
        if ({bus.Busy, bus.armD, bus.PCRedirect, bus.StallF, bus.SwitchCnt} !== {4'b0000, 16'd0})
            $display("FAIL reset_mid_drain: Busy=%b armD=%b redir=%b StallF=%b cnt=%0d expected all 0",
                     bus.Busy, bus.armD, bus.PCRedirect, bus.StallF, bus.SwitchCnt);
        else n_pass++;
        dropped = sb_q.pop_back();
        @(negedge clk);
        rst = 1'b1;
        busy_seen = 0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (bus.Busy !== 1'b0) busy_seen++;
        end
        n_chk++;
        if (busy_seen != 0 || bus.armD !== 1'b0)
            $display("FAIL post_reset_idle: busy cycles=%0d armD=%b expected 0 0", busy_seen, bus.armD);
        else n_pass++;
    endtask

    task automatic test_cnt_wrap();
        logic arm;
        for (int k = 1; k <= 17; k++) begin
            arm = ~bus_w.armD;
            @(negedge clk);
            bus_w.SwitchReqE = 1'b1; bus_w.SwitchArmE = arm; bus_w.SwitchTargetE = 32'h0000_5003;
            @(negedge clk);
            bus_w.SwitchReqE = 1'b0;
            @(negedge clk);
            @(negedge clk);
            #1;
            n_chk++;
            if ({bus_w.PCRedirect, bus_w.PCTarget} !== {1'b1, (arm ? 32'h0000_5000 : 32'h0000_5002)})
                $display("FAIL wrap_redirect_%0d: redir=%b tgt=%h", k, bus_w.PCRedirect, bus_w.PCTarget);
            else n_pass++;
            @(negedge clk);
            #1;
            n_chk++;
            if ({bus_w.armD, bus_w.SwitchCnt} !== {arm, 4'(k)})
                $display("FAIL wrap_cnt_%0d: armD=%b cnt=%0d expected %b %0d",
                         k, bus_w.armD, bus_w.SwitchCnt, arm, 4'(k));
            else n_pass++;
        end
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        test_reset();
        do_switch(1'b1, 32'h0000_1006, 32'h0000_1004, 1'b0, 16'd1);
        do_switch(1'b0, 32'h0000_2003, 32'h0000_2002, 1'b0, 16'd2);
        test_same_mode();
        test_passthrough();
        do_switch(1'b1, 32'hABCD_EF07, 32'hABCD_EF04, 1'b1, 16'd3);
        do_switch(1'b0, 32'h1234_567F, 32'h1234_567E, 1'b1, 16'd4);
        test_reset_mid_drain();
        do_switch(1'b1, 32'h0000_0FFF, 32'h0000_0FFC, 1'b0, 16'd1);
        test_cnt_wrap();
        repeat (2) @(negedge clk);
        n_chk++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_drain: %0d redirects missing, expected 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
